// File: rtl/iis_pkg.sv
// iis_pkg: shared state encoding and channel constants for the I2S slave receiver
package iis_pkg;
  typedef enum logic [1:0] {IIS_IDLE, IIS_HUNT, IIS_SHIFT} iis_rx_state_e;
  localparam logic IIS_LEFT  = 1'b0;
  localparam logic IIS_RIGHT = 1'b1;
endpackage

// File: rtl/iis_sync_edge.sv
// iis_sync_edge: synchronises sck/ws/sd into clk and emits a one-cycle sck rising-edge strobe
module iis_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_o,
  output logic sd_o
);
  logic [STAGES-1:0] sck_q, ws_q, sd_q;
  logic sck_prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q      <= '0;
      ws_q       <= '0;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[STAGES-2:0], sck_i};
      ws_q       <= {ws_q[STAGES-2:0], ws_i};
      sd_q       <= {sd_q[STAGES-2:0], sd_i};
      sck_prev_q <= sck_q[STAGES-1];
    end
  end
  assign sck_rise_o = sck_q[STAGES-1] & ~sck_prev_q;
  assign ws_o       = ws_q[STAGES-1];
  assign sd_o       = sd_q[STAGES-1];
endmodule

// File: rtl/iis_slave_rx.sv
// iis_slave_rx: Philips I2S slave deserialiser with channel tagging and a small valid/ready output FIFO
module iis_slave_rx
  import iis_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic                          sd_i,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_right,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          ovf_clr,
  output logic                          ovf,
  output logic                          locked,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  logic sck_rise, ws_s, sd_s;
  iis_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(pclk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .sck_rise_o(sck_rise), .ws_o(ws_s), .sd_o(sd_s)
  );
  iis_rx_state_e state_q;
  logic ws_prev_q, locked_q, push_q, push_right_q;
  logic [CW-1:0] bit_cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, sh_d, push_data_q;
  logic room, ws_chg;
  assign room   = bit_cnt_q < CW'(DATA_W);
  assign sh_d   = room ? {shreg_q[DATA_W-2:0], sd_s} : shreg_q;
  assign cnt_d  = room ? bit_cnt_q + CW'(1) : bit_cnt_q;
  assign ws_chg = ws_s != ws_prev_q;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IIS_IDLE;
      ws_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      locked_q     <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_right_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (sck_rise) ws_prev_q <= ws_s;
      if (!rx_en) begin
        state_q   <= IIS_IDLE;
        locked_q  <= 1'b0;
        bit_cnt_q <= '0;
        shreg_q   <= '0;
      end else begin
        case (state_q)
          IIS_IDLE: state_q <= IIS_HUNT;
          IIS_HUNT: if (sck_rise && ws_chg) begin
            state_q   <= IIS_SHIFT;
            locked_q  <= 1'b1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
          end
          default: if (sck_rise) begin
            if (ws_chg) begin
              // the edge bit is the LSB of the finishing word; left-align short words
              push_q       <= 1'b1;
              push_data_q  <= sh_d << (CW'(DATA_W) - cnt_d);
              push_right_q <= ws_prev_q == IIS_RIGHT;
              bit_cnt_q    <= '0;
              shreg_q      <= '0;
            end else begin
              shreg_q   <= sh_d;
              bit_cnt_q <= cnt_d;
            end
          end
        endcase
      end
    end
  end
  assign locked = locked_q;
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, level;
  logic ovf_q, full, pop, wr;
  assign level = wptr_q - rptr_q;
  assign full  = level == (AW+1)'(FIFO_DEPTH);
  assign pop   = rx_valid & rx_ready;
  assign wr    = push_q & (~full | pop);
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) mem_q[wptr_q[AW-1:0]] <= {push_right_q, push_data_q};
      wptr_q <= wptr_q + {{AW{1'b0}}, wr};
      rptr_q <= rptr_q + {{AW{1'b0}}, pop};
      ovf_q  <= (push_q & ~wr) | (ovf_q & ~ovf_clr);
    end
  end
  assign rx_valid = level != '0;
  assign rx_level = level;
  assign rx_data  = mem_q[rptr_q[AW-1:0]][DATA_W-1:0];
  assign rx_right = mem_q[rptr_q[AW-1:0]][DATA_W];
  assign ovf      = ovf_q;
endmodule
